// File: rtl/piso_serializer8.sv
// Parallel-in/serial-out transmitter: captures a word on ld, shifts it out one bit
// per clock on sout, with registered busy and a one-cycle done pulse per word.
module piso_serializer8 #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ld,
  input  logic [WIDTH-1:0] din,
  output logic             sout,
  output logic             busy,
  output logic             done
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             sout_q, sout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             accept;

  // A load is taken when idle or on the final bit, which gives gapless back-to-back words.
  assign accept = ld && (state_q == IDLE || cnt_q == LAST);

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    sout_d  = sout_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    if (accept) begin
      shreg_d = din;
      sout_d  = MSB_FIRST ? din[WIDTH-1] : din[0];
      cnt_d   = '0;
      busy_d  = 1'b1;
      state_d = SHIFT;
      done_d  = (state_q == SHIFT);
    end else if (state_q == SHIFT) begin
      if (cnt_q == LAST) begin
        state_d = IDLE;
        busy_d  = 1'b0;
        sout_d  = 1'b0;
        done_d  = 1'b1;
        cnt_d   = '0;
      end else begin
        // shreg shifts so the next bit always sits one place in from the output end
        shreg_d = MSB_FIRST ? (shreg_q << 1) : (shreg_q >> 1);
        sout_d  = MSB_FIRST ? shreg_q[WIDTH-2] : shreg_q[1];
        cnt_d   = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      sout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      sout_q  <= sout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign sout = sout_q;
  assign busy = busy_q;
  assign done = done_q;
endmodule

// File: tb/tb_piso_serializer8.sv
// Scoreboard bench for piso_serializer8: MSB-first and LSB-first instances share clock
// and reset; expected bits are queued at each accepted load and popped per bit time.
module tb_piso_serializer8;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       ld = 1'b0, ld_l = 1'b0;
  logic [7:0] din = '0, din_l = '0;
  logic       sout, busy, done;
  logic       sout_l, busy_l, done_l;

  int n_chk = 0, n_err = 0;
  int done_cnt = 0, done_l_cnt = 0;
  int exp_done = 0, exp_done_l = 0;
  bit exp_q[$];
  bit exp_l_q[$];

  always #5 clk = ~clk;

  piso_serializer8 #(.WIDTH(8), .MSB_FIRST(1'b1)) dut (
    .clk(clk), .reset(reset), .ld(ld), .din(din),
    .sout(sout), .busy(busy), .done(done));

  piso_serializer8 #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .reset(reset), .ld(ld_l), .din(din_l),
    .sout(sout_l), .busy(busy_l), .done(done_l));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Bit-time monitor: every busy cycle must carry the next scoreboard bit.
  always @(negedge clk) begin
    if (busy) begin
      if (exp_q.size() == 0) chk("extra_bit", 1, 0);
      else chk("sout", sout, exp_q.pop_front());
    end else chk("idle_sout", sout, 0);
    if (busy_l) begin
      if (exp_l_q.size() == 0) chk("extra_bit_l", 1, 0);
      else chk("sout_l", sout_l, exp_l_q.pop_front());
    end else chk("idle_sout_l", sout_l, 0);
    if (done) done_cnt++;
    if (done_l) done_l_cnt++;
  end

  // Drives a one-cycle load; returns 1 time unit after the accepting edge.
  task automatic load_word(input logic [7:0] w, input bit lsb);
    @(negedge clk);
    if (lsb) begin ld_l = 1'b1; din_l = w; end
    else begin ld = 1'b1; din = w; end
    @(posedge clk);
    if (lsb) for (int i = 0; i < 8; i++) exp_l_q.push_back(w[i]);
    else for (int i = 7; i >= 0; i--) exp_q.push_back(w[i]);
    #1;
    ld = 1'b0; ld_l = 1'b0;
    din = 8'($urandom); din_l = 8'($urandom);
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (!busy && !busy_l && exp_q.size() == 0 && exp_l_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("idle_timeout", 0, 1);
    @(negedge clk); #1;
  endtask

  initial begin
    // 1: reset held with a load pending must not capture
    ld = 1'b1; din = 8'hFF;
    #1;
    chk("rst_sout", sout, 0); chk("rst_busy", busy, 0); chk("rst_done", done, 0);
    repeat (4) @(posedge clk);
    #1;
    chk("rst_busy_hold", busy, 0);
    ld = 1'b0;
    @(negedge clk); reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("post_rst_busy", busy, 0);
    chk("post_rst_q", exp_q.size(), 0);

    // 2: MSB-first A5, done with busy low right after the 8th bit
    load_word(8'hA5, 1'b0);
    chk("a5_busy", busy, 1);
    repeat (8) @(posedge clk);
    #1;
    chk("a5_done", done, 1); chk("a5_busy_end", busy, 0); chk("a5_sout_end", sout, 0);
    @(posedge clk); #1;
    chk("a5_done_1cyc", done, 0);
    exp_done++;
    wait_idle();
    chk("a5_done_cnt", done_cnt, exp_done);

    // 3: load attempt mid-word is ignored
    load_word(8'h0F, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk); ld = 1'b1; din = 8'hF0;
    @(posedge clk); #1; ld = 1'b0;
    exp_done++;
    wait_idle();
    repeat (3) @(posedge clk);
    #1;
    chk("midld_busy", busy, 0);
    chk("midld_done_cnt", done_cnt, exp_done);

    // 4: back-to-back FF then 00 with no gap
    load_word(8'hFF, 1'b0);
    repeat (7) @(posedge clk);
    load_word(8'h00, 1'b0);
    chk("b2b_busy", busy, 1); chk("b2b_done", done, 1);
    exp_done += 2;
    wait_idle();
    chk("b2b_done_cnt", done_cnt, exp_done);

    // 5: async reset mid-word aborts without done
    load_word(8'h55, 1'b0);
    repeat (4) @(posedge clk);
    #2; reset = 1'b0;
    #1;
    chk("abort_sout", sout, 0); chk("abort_busy", busy, 0); chk("abort_done", done, 0);
    exp_q.delete();
    @(negedge clk); reset = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("abort_idle", busy, 0);
    chk("abort_done_cnt", done_cnt, exp_done);
    load_word(8'h3C, 1'b0);
    exp_done++;
    wait_idle();
    chk("3c_done_cnt", done_cnt, exp_done);

    // 6: LSB-first instance
    load_word(8'h01, 1'b1);
    repeat (8) @(posedge clk);
    #1;
    chk("lsb_done", done_l, 1); chk("lsb_busy_end", busy_l, 0);
    exp_done_l++;
    wait_idle();
    load_word(8'hB2, 1'b1);
    exp_done_l++;
    wait_idle();
    chk("lsb_done_cnt", done_l_cnt, exp_done_l);
    chk("msb_done_final", done_cnt, exp_done);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
